mac_tx_fcs_insert: RTL and testbench

Transmit-side MAC stage that appends the 32-bit Ethernet FCS to each outgoing frame. It accepts a lane-packed byte stream of N_SYMBOLS symbols per beat, drives an internal `mac_crc32` instance, and re-emits the frame with the four FCS bytes packed directly after the last data byte. It sits between the TX frame source (preamble/SFD already stripped) and the TX encoder/IPG stage.

---
 rtl/mac_params.sv | 56 +++++
 rtl/mac_crc32.sv | 38 +++
 rtl/mac_tx_fcs_insert_chk.sv | 24 ++
 rtl/mac_tx_fcs_insert.sv | 117 +++++++++++
 tb/tb_mac_tx_fcs_insert.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_params.sv
// Shared MAC TX parameters, the FCS-insert FSM state type and the CRC-32 / lane-packing helpers.
package mac_params;

  localparam int N_SYMBOLS   = 4;
  localparam int W_SYMBOL    = 8;
  localparam int W_CRC       = 32;
  localparam int W_FCS_BYTES = W_CRC / W_SYMBOL;
  localparam int W_LANE_CNT  = $clog2(N_SYMBOLS + 1);
  localparam int W_CAT_IDX   = $clog2(N_SYMBOLS + W_FCS_BYTES);

  localparam logic [W_CRC-1:0] CRC_RESET = 32'hFFFF_FFFF;
  localparam logic [W_CRC-1:0] CRC_POLY  = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_LAST = 2'd1,
    S_TAIL = 2'd2
  } tx_fcs_state_t;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [W_CRC-1:0] crc32_byte(input logic [W_CRC-1:0] crc,
                                                  input logic [W_SYMBOL-1:0] data);
    logic [W_CRC-1:0] c;
    c = crc ^ {{(W_CRC-W_SYMBOL){1'b0}}, data};
    for (int i = 0; i < W_SYMBOL; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC_POLY;
      else      c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [W_LANE_CNT-1:0] lane_count(input logic [N_SYMBOLS-1:0] valid);
    logic [W_LANE_CNT-1:0] n;
    n = '0;
    for (int i = 0; i < N_SYMBOLS; i++) n = n + {{(W_LANE_CNT-1){1'b0}}, valid[i]};
    return n;
  endfunction

  function automatic logic [N_SYMBOLS-1:0] lane_mask(input logic [W_LANE_CNT-1:0] k);
    logic [N_SYMBOLS-1:0] m;
    for (int i = 0; i < N_SYMBOLS; i++) m[i] = (W_LANE_CNT'(i) < k);
    return m;
  endfunction

  // Index into {fcs bytes, data bytes}: data bytes sit at 0..N-1, FCS byte j at N+j.
  function automatic logic [W_CAT_IDX-1:0] pack_index(input int lane,
                                                      input logic [W_LANE_CNT-1:0] k,
                                                      input logic tail);
    int idx;
    if (tail)                  idx = lane + N_SYMBOLS + W_FCS_BYTES - int'(k);
    else if (lane < int'(k))   idx = lane;
    else                       idx = lane + N_SYMBOLS - int'(k);
    return W_CAT_IDX'(idx);
  endfunction

endpackage

// File: rtl/mac_crc32.sv
// Ethernet CRC-32 accumulator over a lane-packed byte beat; o_crc is the finished (inverted) FCS.
module mac_crc32
  import mac_params::*;
(
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_clk_en,
  input  logic                               i_crc_clr,
  input  logic [N_SYMBOLS-1:0]               i_crc_en,
  input  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] i_data,
  output logic [W_CRC-1:0]                   o_crc
);

  logic [W_CRC-1:0] crc_r;
  logic [W_CRC-1:0] crc_next_s;

  // Fold the enabled lanes in wire order, lane 0 first.
  always_comb begin
    crc_next_s = crc_r;
    for (int lane = 0; lane < N_SYMBOLS; lane++) begin
      if (i_crc_en[lane]) crc_next_s = crc32_byte(crc_next_s, i_data[lane]);
      else                crc_next_s = crc_next_s;
    end
  end

  // CRC state register; clear wins over update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_r <= CRC_RESET;
    end else if (i_clk_en) begin
      if (i_crc_clr) crc_r <= CRC_RESET;
      else           crc_r <= crc_next_s;
    end
  end

  assign o_crc = ~crc_r;

endmodule

// File: rtl/mac_tx_fcs_insert_chk.sv
// Protocol checker for accepted input beats of mac_tx_fcs_insert.
module mac_tx_fcs_insert_chk
  import mac_params::*;
(
  input logic                 i_clk,
  input logic                 i_reset,
  input logic                 i_accept,
  input logic [N_SYMBOLS-1:0] i_valid,
  input logic                 i_eof
);

  localparam logic [N_SYMBOLS-1:0] LANE0 = N_SYMBOLS'(1);

  // A mask is contiguous from lane 0 exactly when adding one clears every set bit.
  always @(posedge i_clk) begin
    if (!i_reset && i_accept) begin
      assert ((i_valid & (i_valid + LANE0)) == '0)
        else $fatal(1, "i_valid mask %b is not contiguous from lane 0", i_valid);
      assert (i_eof || (i_valid == '1))
        else $fatal(1, "non-last beat carries partial i_valid mask %b", i_valid);
    end
  end

endmodule

// File: rtl/mac_tx_fcs_insert.sv
// TX MAC stage appending the 32-bit FCS directly after the last data byte of each frame.
module mac_tx_fcs_insert
  import mac_params::*;
(
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_clk_en,
  input  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] i_data,
  input  logic [N_SYMBOLS-1:0]               i_valid,
  input  logic                               i_eof,
  output logic                               o_ready,
  output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] o_data,
  output logic [N_SYMBOLS-1:0]               o_valid,
  output logic                               o_eof
);

  tx_fcs_state_t                                   state_r;
  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]              data_r;
  logic [N_SYMBOLS-1:0]                            valid_r;
  logic [W_LANE_CNT-1:0]                           k_r;
  logic [W_CRC-1:0]                                fcs_q;
  logic [W_CRC-1:0]                                crc_s;
  logic                                            accept_s;
  logic                                            crc_clr_s;
  logic [N_SYMBOLS-1:0]                            crc_en_s;
  logic [N_SYMBOLS+W_FCS_BYTES-1:0][W_SYMBOL-1:0]  cat_s;

  assign o_ready   = (state_r != S_LAST);
  assign accept_s  = i_clk_en & o_ready & (|i_valid);
  assign crc_en_s  = accept_s ? i_valid : '0;
  assign crc_clr_s = (state_r == S_LAST);

  mac_crc32 u_crc (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clk_en  (i_clk_en),
    .i_crc_clr (crc_clr_s),
    .i_crc_en  (crc_en_s),
    .i_data    (i_data),
    .o_crc     (crc_s)
  );

  mac_tx_fcs_insert_chk u_chk (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_accept (accept_s),
    .i_valid  (i_valid),
    .i_eof    (i_eof)
  );

  // FSM plus input-beat register; the beat held in S_LAST is the frame's last data beat.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= S_DATA;
      data_r  <= '0;
      valid_r <= '0;
      k_r     <= '0;
      fcs_q   <= '0;
    end else if (i_clk_en) begin
      case (state_r)
        S_LAST: begin
          fcs_q   <= crc_s;
          state_r <= S_TAIL;
        end
        S_DATA, S_TAIL: begin
          if (accept_s) begin
            data_r  <= i_data;
            valid_r <= i_valid;
            k_r     <= lane_count(i_valid);
            state_r <= i_eof ? S_LAST : S_DATA;
          end else begin
            data_r  <= '0;
            valid_r <= '0;
            state_r <= S_DATA;
          end
        end
        default: state_r <= S_DATA;
      endcase
    end
  end

  // Output lane packing; in S_LAST the CRC register already covers the whole frame.
  always_comb begin
    cat_s   = {((state_r == S_TAIL) ? fcs_q : crc_s), data_r};
    o_data  = '0;
    o_valid = '0;
    o_eof   = 1'b0;
    case (state_r)
      S_DATA: begin
        o_data  = data_r;
        o_valid = valid_r;
        o_eof   = 1'b0;
      end
      S_LAST: begin
        for (int lane = 0; lane < N_SYMBOLS; lane++) begin
          o_data[lane] = cat_s[pack_index(lane, k_r, 1'b0)];
        end
        o_valid = '1;
        o_eof   = 1'b0;
      end
      S_TAIL: begin
        for (int lane = 0; lane < N_SYMBOLS; lane++) begin
          if (W_LANE_CNT'(lane) < k_r) o_data[lane] = cat_s[pack_index(lane, k_r, 1'b1)];
          else                         o_data[lane] = '0;
        end
        o_valid = lane_mask(k_r);
        o_eof   = 1'b1;
      end
      default: begin
        o_data  = '0;
        o_valid = '0;
        o_eof   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_tx_fcs_insert.sv
// Bench for mac_tx_fcs_insert: directed and random frames checked against a byte-stream FCS model.
module tb_mac_tx_fcs_insert;
  import mac_params::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  valid;
    logic        eof;
  } beat_t;

  logic                               clk = 1'b0;
  logic                               i_reset = 1'b1;
  logic                               i_clk_en = 1'b1;
  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] i_data = '0;
  logic [N_SYMBOLS-1:0]               i_valid = '0;
  logic                               i_eof = 1'b0;
  logic                               o_ready;
  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] o_data;
  logic [N_SYMBOLS-1:0]               o_valid;
  logic                               o_eof;

  always #5 clk = ~clk;

  mac_tx_fcs_insert dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_clk_en (i_clk_en),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_eof    (i_eof),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_eof    (o_eof)
  );

  beat_t       got_q[$];
  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_low = 0;
  int          duty = 100;
  logic        mon_on = 1'b0;
  logic        prev_en = 1'b1;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_valid = '0;
  logic        prev_eof = 1'b0;
  logic        prev_ready = 1'b1;

  // Software CRC-32, one bit at a time.
  function automatic logic [31:0] crc_ref(input byte_q_t b);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  function automatic logic [31:0] keep_lanes(input logic [31:0] d, input logic [3:0] v);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) if (v[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  // Expected wire image: frame bytes then FCS bytes, chunked 4 per beat, eof on the final chunk.
  task automatic expect_frame(input byte_q_t b);
    byte_q_t     w;
    logic [31:0] crc;
    beat_t       bt;
    w   = b;
    crc = crc_ref(b);
    for (int j = 0; j < 4; j++) w.push_back(crc[8*j +: 8]);
    for (int i = 0; i < w.size(); i += 4) begin
      bt = '0;
      for (int l = 0; l < 4; l++) begin
        if (i + l < w.size()) begin
          bt.data[8*l +: 8] = w[i+l];
          bt.valid[l]       = 1'b1;
        end
      end
      bt.eof = (i + 4 >= w.size());
      exp_q.push_back(bt);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    assert (got === req) else begin
      n_fail++;
      $error("FAIL %s: got %h, required %h", tag, got, req);
    end
  endtask

  // Negedge monitor: hold check after disabled edges, beat capture, idle and ready tracking.
  task automatic sample();
    if (mon_on && !prev_en && !prev_rst) begin
      n_checks++;
      assert ({o_data, o_valid, o_eof, o_ready} === {prev_data, prev_valid, prev_eof, prev_ready}) else begin
        n_fail++;
        $error("FAIL hold: got %h/%b/%b/%b, required %h/%b/%b/%b", o_data, o_valid, o_eof, o_ready,
               prev_data, prev_valid, prev_eof, prev_ready);
      end
    end
    if (mon_on && i_clk_en && !i_reset) begin
      if (|o_valid) begin
        got_q.push_back(beat_t'{data: keep_lanes(o_data, o_valid), valid: o_valid, eof: o_eof});
      end else begin
        n_checks++;
        assert ({o_data, o_eof} === 33'h0) else begin
          n_fail++;
          $error("FAIL idle: got data=%h eof=%b, required data=0 eof=0", o_data, o_eof);
        end
      end
      if (!o_ready) ready_low++;
    end
    prev_en    = i_clk_en;
    prev_rst   = i_reset;
    prev_data  = o_data;
    prev_valid = o_valid;
    prev_eof   = o_eof;
    prev_ready = o_ready;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    i_data   = '0;
    i_valid  = '0;
    i_eof    = 1'b0;
    i_clk_en = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_frame(input byte_q_t b);
    logic [31:0] d;
    logic [3:0]  v;
    logic        acc;
    int          guard;
    for (int i = 0; i < b.size(); i += 4) begin
      d = '0;
      v = '0;
      for (int l = 0; l < 4; l++) begin
        if (i + l < b.size()) begin
          d[8*l +: 8] = b[i+l];
          v[l]        = 1'b1;
        end
      end
      i_data = d;
      i_valid = v;
      i_eof = (i + 4 >= b.size());
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        i_clk_en = ($urandom_range(99) < duty);
        acc = i_clk_en && o_ready;
        step();
        guard++;
      end
      n_checks++;
      assert (acc === 1'b1) else begin
        n_fail++;
        $error("FAIL accept: beat %0d not taken after %0d cycles, required acceptance", i / 4, guard);
      end
    end
    i_data   = '0;
    i_valid  = '0;
    i_eof    = 1'b0;
    i_clk_en = 1'b1;
  endtask

  task automatic check_stream(input string tag);
    n_checks++;
    assert (got_q.size() === exp_q.size()) else begin
      n_fail++;
      $error("FAIL %s beat count: got %0d, required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      assert (got_q[i] === exp_q[i]) else begin
        n_fail++;
        $error("FAIL %s beat %0d: got data=%h valid=%b eof=%b, required data=%h valid=%b eof=%b",
               tag, i, got_q[i].data, got_q[i].valid, got_q[i].eof,
               exp_q[i].data, exp_q[i].valid, exp_q[i].eof);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    byte_q_t fa;
    byte_q_t fb;

    // Reset state.
    i_reset = 1'b1;
    repeat (3) step();
    chk("reset_o_data", 64'(o_data), 64'h0);
    chk("reset_o_valid", 64'(o_valid), 64'h0);
    chk("reset_o_eof", 64'(o_eof), 64'h0);
    chk("reset_o_ready", 64'(o_ready), 64'h1);
    i_reset = 1'b0;
    mon_on  = 1'b1;
    drain(2);

    // Check-value frame "123456789", k = 1, against literal beats.
    fa = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_check_value", 64'(crc_ref(fa)), 64'hCBF4_3926);
    exp_q.push_back(beat_t'{data: 32'h3433_3231, valid: 4'hF, eof: 1'b0});
    exp_q.push_back(beat_t'{data: 32'h3837_3635, valid: 4'hF, eof: 1'b0});
    exp_q.push_back(beat_t'{data: 32'hF439_2639, valid: 4'hF, eof: 1'b0});
    exp_q.push_back(beat_t'{data: 32'h0000_00CB, valid: 4'h1, eof: 1'b1});
    send_frame(fa);
    drain(4);
    check_stream("check_value_k1");

    // Eight-byte frame, k = 4.
    fa = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    expect_frame(fa);
    send_frame(fa);
    drain(4);
    check_stream("eight_byte_k4");

    // Back-to-back 64-byte frames: one ready bubble per frame.
    fa = rand_bytes(64);
    fb = rand_bytes(64);
    expect_frame(fa);
    expect_frame(fb);
    ready_low = 0;
    send_frame(fa);
    send_frame(fb);
    drain(4);
    chk("b2b_ready_low_beats", 64'(ready_low), 64'd2);
    check_stream("b2b_64");

    // 61-byte frame with a 30% clock-enable duty cycle.
    fa = rand_bytes(61);
    expect_frame(fa);
    duty = 30;
    send_frame(fa);
    duty = 100;
    drain(4);
    check_stream("clk_en_30pct");

    // Reset while in S_LAST discards the frame; the next frame is clean.
    fa = rand_bytes(10);
    send_frame(fa);
    chk("in_s_last_ready", 64'(o_ready), 64'h0);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("after_reset_o_valid", 64'(o_valid), 64'h0);
    chk("after_reset_o_ready", 64'(o_ready), 64'h1);
    got_q.delete();
    drain(2);
    fb = rand_bytes(23);
    expect_frame(fb);
    send_frame(fb);
    drain(4);
    check_stream("after_reset");

    // Single-beat frames sweeping k = 1..4.
    for (int k = 1; k <= 4; k++) begin
      fa = rand_bytes(k);
      expect_frame(fa);
      send_frame(fa);
    end
    drain(4);
    check_stream("k_sweep");

    // Random lengths and enable duty cycles.
    for (int f = 0; f < 6; f++) begin
      fa = rand_bytes($urandom_range(40, 1));
      expect_frame(fa);
      duty = $urandom_range(100, 40);
      send_frame(fa);
    end
    duty = 100;
    drain(6);
    check_stream("random_frames");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
